// File: rtl/kernel_pkg.sv
// rtl/kernel_pkg.sv - shared defaults and state encoding for the kernel sum path
package kernel_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_KSIZE  = 9;
  localparam int DEF_CNT_W  = 4;
  localparam int DEF_SHIFT  = 0;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_ACC  = ST_ACC,
    S_DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/kernel_add16.sv
// rtl/kernel_add16.sv - shared combinational adder a+b+cin with carry out
module kernel_add16 #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  // Widen by one bit so the carry falls out of the top of the sum
  always_comb begin
    {cout, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  end

endmodule

// File: rtl/kernel_sum_ctrl.sv
// rtl/kernel_sum_ctrl.sv - accumulates one kernel window and holds the result
module kernel_sum_ctrl
  import kernel_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int KSIZE  = DEF_KSIZE,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int SHIFT  = DEF_SHIFT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] sum_out,
  output logic              sum_valid,
  input  logic              sum_ready,
  output logic              overflow,
  output logic              busy
);

  state_t            state;
  logic [DATA_W-1:0] acc;
  logic [CNT_W-1:0]  cnt;
  logic              ovf;

  logic [DATA_W-1:0] add_s;
  logic              add_cout;
  logic              accept;
  logic              last;

  assign accept = in_valid & in_ready;
  assign last   = (cnt == CNT_W'(KSIZE - 1));

  // The adder always sees the running sum and the offered sample; its result
  // is only committed on an accepted beat.
  kernel_add16 #(
    .W (DATA_W)
  ) u_add (
    .a    (acc),
    .b    (in_data),
    .cin  (1'b0),
    .s    (add_s),
    .cout (add_cout)
  );

  // Window sequencer; outputs are registered alongside each state change
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      in_ready  <= 1'b0;
      sum_valid <= 1'b0;
      sum_out   <= '0;
      overflow  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            acc      <= '0;
            cnt      <= '0;
            ovf      <= 1'b0;
            state    <= S_ACC;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        S_ACC: begin
          if (accept) begin
            acc <= add_s;
            ovf <= ovf | add_cout;
            cnt <= cnt + 1'b1;
            if (last) begin
              state     <= S_DONE;
              in_ready  <= 1'b0;
              sum_valid <= 1'b1;
              sum_out   <= add_s >> SHIFT;
              overflow  <= ovf | add_cout;
            end
          end
        end
        S_DONE: begin
          if (sum_ready) begin
            sum_valid <= 1'b0;
            sum_out   <= '0;
            overflow  <= 1'b0;
            if (start) begin
              // Back-to-back window: skip IDLE so the next sample can land now
              acc      <= '0;
              cnt      <= '0;
              ovf      <= 1'b0;
              state    <= S_ACC;
              in_ready <= 1'b1;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state     <= S_IDLE;
          in_ready  <= 1'b0;
          sum_valid <= 1'b0;
          sum_out   <= '0;
          overflow  <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kernel_sum_ctrl.sv
// tb/tb_kernel_sum_ctrl.sv - directed self-checking bench for kernel_sum_ctrl
module tb_kernel_sum_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] sum_out;
  logic        sum_valid;
  logic        sum_ready = 1'b0;
  logic        overflow;
  logic        busy;

  logic        s_start = 1'b0;
  logic [15:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_in_ready;
  logic [15:0] s_sum_out;
  logic        s_sum_valid;
  logic        s_overflow;
  logic        s_busy;

  logic        k_start = 1'b0;
  logic [15:0] k_data = '0;
  logic        k_valid = 1'b0;
  logic        k_in_ready;
  logic [15:0] k_sum_out;
  logic        k_sum_valid;
  logic        k_overflow;
  logic        k_busy;

  int checks = 0;
  int errors = 0;
  int edges;

  always #5 clk = ~clk;

  kernel_sum_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .sum_out(sum_out), .sum_valid(sum_valid),
    .sum_ready(sum_ready), .overflow(overflow), .busy(busy)
  );

  kernel_sum_ctrl #(.SHIFT(3)) dut_shift (
    .clk(clk), .rst(rst), .start(s_start), .in_data(s_data), .in_valid(s_valid),
    .in_ready(s_in_ready), .sum_out(s_sum_out), .sum_valid(s_sum_valid),
    .sum_ready(1'b1), .overflow(s_overflow), .busy(s_busy)
  );

  kernel_sum_ctrl #(.KSIZE(1)) dut_k1 (
    .clk(clk), .rst(rst), .start(k_start), .in_data(k_data), .in_valid(k_valid),
    .in_ready(k_in_ready), .sum_out(k_sum_out), .sum_valid(k_sum_valid),
    .sum_ready(1'b1), .overflow(k_overflow), .busy(k_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    edges++;
  endtask

  task automatic do_start();
    start = 1'b1;
    edges = 0;
    tick();
    start = 1'b0;
  endtask

  // Offer one sample after 'gap' idle cycles; the window must be open throughout
  task automatic feed(input logic [15:0] v, input int gap);
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      in_data  = 16'hDEAD;
      tick();
      checks++;
      if (in_ready !== 1'b1 || sum_valid !== 1'b0) begin
        errors++;
        $display("FAIL gap_ready in_ready=%b sum_valid=%b want 1/0", in_ready, sum_valid);
      end
    end
    in_valid = 1'b1;
    in_data  = v;
    checks++;
    if (in_ready !== 1'b1 || sum_valid !== 1'b0) begin
      errors++;
      $display("FAIL feed_ready in_ready=%b sum_valid=%b want 1/0", in_ready, sum_valid);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || sum_valid !== 1'b0 || sum_out !== 16'd0 ||
        overflow !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs rdy=%b sv=%b sum=%h ovf=%b busy=%b want all 0",
               in_ready, sum_valid, sum_out, overflow, busy);
    end
    checks++;
    if (s_busy !== 1'b0 || s_sum_valid !== 1'b0 || k_busy !== 1'b0 || k_sum_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_variants s_busy=%b s_sv=%b k_busy=%b k_sv=%b want 0",
               s_busy, s_sum_valid, k_busy, k_sum_valid);
    end
  endtask

  task automatic test_basic();
    sum_ready = 1'b1;
    do_start();
    for (int i = 0; i < 9; i++) feed(16'd1, 0);
    checks++;
    if (sum_valid !== 1'b1 || sum_out !== 16'd9 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL basic_sum sv=%b sum=%0d ovf=%b want 1/9/0", sum_valid, sum_out, overflow);
    end
    checks++;
    if (edges !== 10) begin
      errors++;
      $display("FAIL basic_latency cycles=%0d want 10", edges);
    end
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_flags busy=%b in_ready=%b want 1/0", busy, in_ready);
    end
    tick();
    checks++;
    if (sum_valid !== 1'b0 || sum_out !== 16'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_one_cycle sv=%b sum=%0d busy=%b want 0/0/0", sum_valid, sum_out, busy);
    end
  endtask

  task automatic test_overflow();
    sum_ready = 1'b1;
    do_start();
    for (int i = 0; i < 9; i++) feed(16'hFFFF, 0);
    checks++;
    if (sum_valid !== 1'b1 || sum_out !== 16'hFFF7 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_sum sv=%b sum=%h ovf=%b want 1/fff7/1", sum_valid, sum_out, overflow);
    end
    tick();
    checks++;
    if (overflow !== 1'b0 || sum_valid !== 1'b0) begin
      errors++;
      $display("FAIL overflow_clear ovf=%b sv=%b want 0/0", overflow, sum_valid);
    end
  endtask

  task automatic test_gaps();
    sum_ready = 1'b1;
    do_start();
    for (int i = 1; i <= 9; i++) feed(16'(i * 10), 2);
    checks++;
    if (sum_valid !== 1'b1 || sum_out !== 16'd450 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL gaps_sum sv=%b sum=%0d ovf=%b want 1/450/0", sum_valid, sum_out, overflow);
    end
    tick();
  endtask

  task automatic test_hold();
    sum_ready = 1'b0;
    do_start();
    for (int i = 0; i < 9; i++) feed(16'd5, 0);
    for (int c = 0; c < 5; c++) begin
      in_valid = c[0];
      in_data  = 16'd100;
      tick();
      checks++;
      if (sum_valid !== 1'b1 || sum_out !== 16'd45 || overflow !== 1'b0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_stable c=%0d sv=%b sum=%0d ovf=%b rdy=%b want 1/45/0/0",
                 c, sum_valid, sum_out, overflow, in_ready);
      end
    end
    in_valid  = 1'b0;
    sum_ready = 1'b1;
    tick();
    checks++;
    if (sum_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL hold_release sv=%b busy=%b want 0/0", sum_valid, busy);
    end
  endtask

  task automatic test_reset_mid();
    sum_ready = 1'b1;
    do_start();
    for (int i = 0; i < 4; i++) feed(16'd7, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || sum_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_idle busy=%b rdy=%b sv=%b want 0/0/0", busy, in_ready, sum_valid);
    end
    tick();
    tick();
    checks++;
    if (sum_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_stale sv=%b want 0", sum_valid);
    end
    do_start();
    for (int i = 0; i < 9; i++) feed(16'd2, 0);
    checks++;
    if (sum_valid !== 1'b1 || sum_out !== 16'd18 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL midreset_sum sv=%b sum=%0d ovf=%b want 1/18/0", sum_valid, sum_out, overflow);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    sum_ready = 1'b0;
    do_start();
    for (int i = 0; i < 9; i++) feed(16'hFFFF, 0);
    checks++;
    if (sum_valid !== 1'b1 || sum_out !== 16'hFFF7 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first sv=%b sum=%h ovf=%b want 1/fff7/1", sum_valid, sum_out, overflow);
    end
    sum_ready = 1'b1;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    sum_ready = 1'b0;
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1 || sum_valid !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL b2b_rearm busy=%b rdy=%b sv=%b ovf=%b want 1/1/0/0",
               busy, in_ready, sum_valid, overflow);
    end
    for (int i = 0; i < 9; i++) begin
      start = (i == 3);
      feed(16'd3, 0);
    end
    start = 1'b0;
    checks++;
    if (sum_valid !== 1'b1 || sum_out !== 16'd27 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second sv=%b sum=%0d ovf=%b want 1/27/0", sum_valid, sum_out, overflow);
    end
    sum_ready = 1'b1;
    tick();
  endtask

  task automatic test_shift();
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      s_valid = 1'b1;
      s_data  = 16'd8;
      tick();
    end
    s_valid = 1'b0;
    checks++;
    if (s_sum_valid !== 1'b1 || s_sum_out !== 16'd9 || s_overflow !== 1'b0) begin
      errors++;
      $display("FAIL shift_sum sv=%b sum=%0d ovf=%b want 1/9/0", s_sum_valid, s_sum_out, s_overflow);
    end
    tick();
  endtask

  task automatic test_ksize1();
    k_start = 1'b1;
    tick();
    k_start = 1'b0;
    checks++;
    if (k_in_ready !== 1'b1 || k_sum_valid !== 1'b0) begin
      errors++;
      $display("FAIL k1_open rdy=%b sv=%b want 1/0", k_in_ready, k_sum_valid);
    end
    k_valid = 1'b1;
    k_data  = 16'd1234;
    tick();
    k_valid = 1'b0;
    checks++;
    if (k_sum_valid !== 1'b1 || k_sum_out !== 16'd1234 || k_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL k1_sum sv=%b sum=%0d rdy=%b want 1/1234/0", k_sum_valid, k_sum_out, k_in_ready);
    end
    tick();
    checks++;
    if (k_sum_valid !== 1'b0 || k_busy !== 1'b0) begin
      errors++;
      $display("FAIL k1_idle sv=%b busy=%b want 0/0", k_sum_valid, k_busy);
    end
  endtask

  initial begin
    edges = 0;
    #1;
    test_reset();
    test_basic();
    test_overflow();
    test_gaps();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    test_shift();
    test_ksize1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
